// File: rtl/cnn_job_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : cnn_job_scheduler_if
// Description : Job request, core control and completion signals of the
//               CNN job scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface cnn_job_scheduler_if #(
    parameter int NUM_CORES = 4,
    parameter int ID_W      = 4,
    parameter int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
);
    logic                 sched_en;
    logic                 job_valid;
    logic [ID_W-1:0]      job_id;
    logic                 job_ready;
    logic [NUM_CORES-1:0] core_start;
    logic [NUM_CORES-1:0] core_clear;
    logic [NUM_CORES-1:0] core_done;
    logic                 cmp_valid;
    logic [ID_W-1:0]      cmp_id;
    logic [CORE_W-1:0]    cmp_core;
    logic                 idle;

    modport master (
        output sched_en, job_valid, job_id, core_done,
        input  job_ready, core_start, core_clear, cmp_valid, cmp_id, cmp_core, idle
    );

    modport slave (
        input  sched_en, job_valid, job_id, core_done,
        output job_ready, core_start, core_clear, cmp_valid, cmp_id, cmp_core, idle
    );
endinterface
`default_nettype wire

// File: rtl/cnn_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cnn_job_scheduler
// Description : FIFO job queue feeding NUM_CORES engines round-robin, with a
//               lowest-index completion arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_job_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int ID_W      = 4,
    parameter int QDEPTH    = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cnn_job_scheduler_if.slave bus
);
    localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W  = $clog2(QDEPTH + 1);

    typedef enum logic [2:0] {
        C_IDLE   = 3'd0,
        C_START  = 3'd1,
        C_RUN    = 3'd2,
        C_REPORT = 3'd3,
        C_CLEAR  = 3'd4
    } core_state_t;

    logic [ID_W-1:0]      r_q [QDEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [CORE_W-1:0]    r_rr_ptr;
    core_state_t          r_state   [NUM_CORES];
    logic [ID_W-1:0]      r_core_id [NUM_CORES];
    logic [NUM_CORES-1:0] r_core_start;
    logic [NUM_CORES-1:0] r_core_clear;
    logic                 r_cmp_valid;
    logic [ID_W-1:0]      r_cmp_id;
    logic [CORE_W-1:0]    r_cmp_core;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_sel_found;
    logic [CORE_W-1:0]    w_sel_idx;
    logic [NUM_CORES-1:0] w_next_report;
    logic                 w_ng_found;
    logic [CORE_W-1:0]    w_ng_idx;
    logic                 w_all_idle;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_ready = (r_count != CNT_W'(QDEPTH));
    assign w_push  = bus.job_valid && w_ready;
    assign w_pop   = bus.sched_en && (r_count != '0) && w_sel_found;

    // Round-robin search for an idle core starting at r_rr_ptr.
    always_comb begin
        int c;
        c           = 0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            c = int'(r_rr_ptr) + i;
            if (c >= NUM_CORES) c = c - NUM_CORES;
            if (!w_sel_found && r_state[c] == C_IDLE) begin
                w_sel_found = 1'b1;
                w_sel_idx   = CORE_W'(c);
            end
        end
    end

    // Cores that will sit in C_REPORT next cycle; the lowest of them is
    // granted now so its report is registered for exactly that cycle.
    always_comb begin
        w_next_report = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (r_state[i] == C_REPORT)
                w_next_report[i] = !(r_cmp_valid && r_cmp_core == CORE_W'(i));
            else if (r_state[i] == C_RUN)
                w_next_report[i] = bus.core_done[i];
        end
    end

    always_comb begin
        w_ng_found = 1'b0;
        w_ng_idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (w_next_report[i]) begin
                w_ng_found = 1'b1;
                w_ng_idx   = CORE_W'(i);
            end
        end
    end

    always_comb begin
        w_all_idle = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (r_state[i] != C_IDLE) w_all_idle = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_q[r_wptr] <= bus.job_id;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_rr_ptr     <= '0;
            r_core_start <= '0;
            r_core_clear <= '0;
            r_cmp_valid  <= 1'b0;
            r_cmp_id     <= '0;
            r_cmp_core   <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_state[i]   <= C_IDLE;
                r_core_id[i] <= '0;
            end
        end else begin
            r_core_start <= '0;
            r_core_clear <= '0;

            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop) begin
                r_rptr   <= ptr_inc(r_rptr);
                r_rr_ptr <= (w_sel_idx == CORE_W'(NUM_CORES - 1)) ? '0 : w_sel_idx + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            for (int i = 0; i < NUM_CORES; i++) begin
                case (r_state[i])
                    C_IDLE: begin
                        if (w_pop && w_sel_idx == CORE_W'(i)) begin
                            r_state[i]      <= C_START;
                            r_core_id[i]    <= r_q[r_rptr];
                            r_core_start[i] <= 1'b1;
                        end
                    end
                    C_START: r_state[i] <= C_RUN;
                    C_RUN: begin
                        if (bus.core_done[i]) r_state[i] <= C_REPORT;
                    end
                    C_REPORT: begin
                        if (r_cmp_valid && r_cmp_core == CORE_W'(i)) begin
                            r_state[i]      <= C_CLEAR;
                            r_core_clear[i] <= 1'b1;
                        end
                    end
                    C_CLEAR: r_state[i] <= C_IDLE;
                    default: r_state[i] <= C_IDLE;
                endcase
            end

            r_cmp_valid <= w_ng_found;
            if (w_ng_found) begin
                r_cmp_id   <= r_core_id[w_ng_idx];
                r_cmp_core <= w_ng_idx;
            end
        end
    end

    assign bus.job_ready  = w_ready;
    assign bus.core_start = r_core_start;
    assign bus.core_clear = r_core_clear;
    assign bus.cmp_valid  = r_cmp_valid;
    assign bus.cmp_id     = r_cmp_id;
    assign bus.cmp_core   = r_cmp_core;
    assign bus.idle       = (r_count == '0) && w_all_idle;

endmodule
`default_nettype wire

// File: tb/tb_cnn_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_job_scheduler
// Description : Scenario and randomized checks of cnn_job_scheduler against
//               a transaction-level model with emulated engines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_job_scheduler;
    localparam int NC = 4;
    localparam int IW = 4;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnn_job_scheduler_if #(.NUM_CORES(NC), .ID_W(IW)) bus ();
    cnn_job_scheduler #(.NUM_CORES(NC), .ID_W(IW), .QDEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [NC-1:0] done_r;
    int tmr [NC];
    bit armed [NC];
    int dly [NC];
    bit auto_done;
    bit rand_dly;
    int start_log [$];
    int cmp_core_log [$];
    int cmp_id_log [$];

    // One clock; then emulate engines: done rises a set time after start and
    // stays high until the scheduler clears the engine.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NC; i++) begin
            if (bus.core_clear[i]) done_r[i] = 1'b0;
            if (bus.core_start[i]) begin
                start_log.push_back(i);
                armed[i] = auto_done;
                tmr[i]   = rand_dly ? int'($urandom_range(1, 8)) : dly[i];
            end else if (armed[i]) begin
                if (tmr[i] <= 1) begin
                    done_r[i] = 1'b1;
                    armed[i]  = 1'b0;
                end else begin
                    tmr[i]--;
                end
            end
        end
        if (bus.cmp_valid) begin
            cmp_core_log.push_back(int'(bus.cmp_core));
            cmp_id_log.push_back(int'(bus.cmp_id));
        end
        bus.core_done = done_r;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        bus.sched_en  = 1'b0;
        bus.job_valid = 1'b0;
        bus.job_id    = '0;
        done_r        = '0;
        bus.core_done = '0;
        auto_done     = 1'b1;
        rand_dly      = 1'b0;
        for (int i = 0; i < NC; i++) begin
            armed[i] = 1'b0;
            dly[i]   = 5;
        end
        start_log.delete();
        cmp_core_log.delete();
        cmp_id_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic push_job(input int id, output bit acc);
        bus.job_valid = 1'b1;
        bus.job_id    = IW'(id);
        acc           = bus.job_ready;
        step();
        bus.job_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.sched_en = 1'b0; bus.job_valid = 1'b0; bus.job_id = '0; bus.core_done = '0;
        #1 rst = 1'b0;
        #2;
        total++; if (bus.job_ready !== 1'b1) begin bad++; $display("FAIL reset_job_ready got=%b want=1", bus.job_ready); end
        total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", bus.idle); end
        total++; if (bus.core_start !== '0) begin bad++; $display("FAIL reset_core_start got=%b want=0", bus.core_start); end
        total++; if (bus.core_clear !== '0) begin bad++; $display("FAIL reset_core_clear got=%b want=0", bus.core_clear); end
        total++; if (bus.cmp_valid !== 1'b0) begin bad++; $display("FAIL reset_cmp_valid got=%b want=0", bus.cmp_valid); end
        total++; if (bus.cmp_id !== '0 || bus.cmp_core !== '0) begin bad++; $display("FAIL reset_cmp_fields got=%0d/%0d want=0/0", bus.cmp_id, bus.cmp_core); end
    endtask

    task automatic test_single();
        bit acc;
        int n;
        do_reset();
        bus.sched_en = 1'b1;
        dly[0] = 10;
        push_job(5, acc);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL single_accept got=%b want=1", acc); end
        total++; if (bus.core_start !== 4'b0000) begin bad++; $display("FAIL single_start_latency got=%b want=0000", bus.core_start); end
        step();
        total++; if (bus.core_start !== 4'b0001) begin bad++; $display("FAIL single_start got=%b want=0001", bus.core_start); end
        step();
        total++; if (bus.core_start !== 4'b0000) begin bad++; $display("FAIL single_start_width got=%b want=0000", bus.core_start); end
        n = 0;
        while (!bus.cmp_valid && n < 50) begin step(); n++; end
        total++; if (bus.cmp_valid !== 1'b1) begin bad++; $display("FAIL single_cmp_timeout got=%b want=1", bus.cmp_valid); end
        total++; if (bus.cmp_id !== 4'd5 || bus.cmp_core !== 2'd0) begin bad++; $display("FAIL single_cmp got id=%0d core=%0d want id=5 core=0", bus.cmp_id, bus.cmp_core); end
        step();
        total++; if (bus.core_clear !== 4'b0001 || bus.cmp_valid !== 1'b0) begin bad++; $display("FAIL single_clear got clr=%b cmp=%b want 0001/0", bus.core_clear, bus.cmp_valid); end
        step();
        total++; if (bus.idle !== 1'b1 || bus.core_clear !== 4'b0000) begin bad++; $display("FAIL single_idle got idle=%b clr=%b want 1/0000", bus.idle, bus.core_clear); end
    endtask

    task automatic test_fill();
        bit acc;
        int n;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            push_job(k, acc);
            total++; if (acc !== (k <= 4)) begin bad++; $display("FAIL fill_ready_%0d got=%b want=%b", k, acc, (k <= 4)); end
        end
        total++; if (start_log.size() != 0) begin bad++; $display("FAIL fill_no_dispatch got=%0d want=0", start_log.size()); end
        for (int i = 0; i < NC; i++) dly[i] = 20;
        bus.sched_en = 1'b1;
        for (int k = 0; k < NC; k++) begin
            step();
            total++; if (bus.core_start !== NC'(1 << k)) begin bad++; $display("FAIL fill_start_%0d got=%b want=%b", k, bus.core_start, NC'(1 << k)); end
        end
        n = 0;
        while (cmp_id_log.size() < 4 && n < 100) begin step(); n++; end
        total++; if (cmp_id_log.size() != 4) begin bad++; $display("FAIL fill_cmp_count got=%0d want=4", cmp_id_log.size()); end
        for (int k = 0; k < cmp_id_log.size() && k < 4; k++) begin
            total++; if (cmp_core_log[k] != k || cmp_id_log[k] != k + 1) begin bad++; $display("FAIL fill_cmp_%0d got core=%0d id=%0d want core=%0d id=%0d", k, cmp_core_log[k], cmp_id_log[k], k, k + 1); end
        end
        step(); step();
        total++; if (bus.idle !== 1'b1) begin bad++; $display("FAIL fill_idle got=%b want=1", bus.idle); end
    endtask

    task automatic test_round_robin();
        int exp_core [6] = '{0, 1, 2, 3, 0, 1};
        int pc [NC][$];
        bit acc;
        int n;
        do_reset();
        bus.sched_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!bus.job_ready && n < 50) begin step(); n++; end
            push_job(k + 1, acc);
            pc[exp_core[k]].push_back(k + 1);
        end
        n = 0;
        while (cmp_id_log.size() < 6 && n < 300) begin step(); n++; end
        total++; if (start_log.size() != 6 || cmp_id_log.size() != 6) begin bad++; $display("FAIL rr_counts got starts=%0d cmps=%0d want 6/6", start_log.size(), cmp_id_log.size()); end
        for (int k = 0; k < 6 && k < start_log.size(); k++) begin
            total++; if (start_log[k] != exp_core[k]) begin bad++; $display("FAIL rr_core_%0d got=%0d want=%0d", k, start_log[k], exp_core[k]); end
        end
        for (int k = 0; k < cmp_id_log.size(); k++) begin
            int c;
            c = cmp_core_log[k];
            total++;
            if (pc[c].size() == 0) begin bad++; $display("FAIL rr_extra_cmp got core=%0d id=%0d want none", c, cmp_id_log[k]); end
            else begin
                if (cmp_id_log[k] != pc[c][0]) begin bad++; $display("FAIL rr_cmp_id got=%0d want=%0d core=%0d", cmp_id_log[k], pc[c][0], c); end
                void'(pc[c].pop_front());
            end
        end
    endtask

    task automatic test_collision();
        bit acc;
        do_reset();
        auto_done = 1'b0;
        bus.sched_en = 1'b1;
        for (int k = 0; k < NC; k++) push_job(9 + k, acc);
        repeat (8) step();
        done_r[1] = 1'b1; done_r[3] = 1'b1; bus.core_done = done_r;
        step();
        total++; if (bus.cmp_valid !== 1'b1 || bus.cmp_core !== 2'd1 || bus.cmp_id !== 4'd10) begin bad++; $display("FAIL coll_first got v=%b core=%0d id=%0d want 1/1/10", bus.cmp_valid, bus.cmp_core, bus.cmp_id); end
        step();
        total++; if (bus.cmp_valid !== 1'b1 || bus.cmp_core !== 2'd3 || bus.cmp_id !== 4'd12) begin bad++; $display("FAIL coll_second got v=%b core=%0d id=%0d want 1/3/12", bus.cmp_valid, bus.cmp_core, bus.cmp_id); end
        total++; if (bus.core_clear !== 4'b0010) begin bad++; $display("FAIL coll_clear got=%b want=0010", bus.core_clear); end
        step();
        total++; if (bus.cmp_valid !== 1'b0) begin bad++; $display("FAIL coll_dup got=%b want=0", bus.cmp_valid); end
        done_r[0] = 1'b1; done_r[2] = 1'b1; bus.core_done = done_r;
        repeat (8) step();
        total++; if (cmp_id_log.size() != 4 || bus.idle !== 1'b1) begin bad++; $display("FAIL coll_drain got cmps=%0d idle=%b want 4/1", cmp_id_log.size(), bus.idle); end
    endtask

    task automatic test_spurious();
        do_reset();
        bus.sched_en = 1'b1;
        done_r[2] = 1'b1; bus.core_done = done_r;
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if (bus.cmp_valid !== 1'b0 || bus.core_clear !== '0) begin bad++; $display("FAIL spurious_%0d got cmp=%b clr=%b want 0/0000", k, bus.cmp_valid, bus.core_clear); end
        end
        done_r = '0; bus.core_done = '0;
    endtask

    task automatic test_mid_reset();
        bit acc;
        bit saw;
        do_reset();
        bus.sched_en = 1'b1;
        for (int i = 0; i < NC; i++) dly[i] = 30;
        for (int k = 0; k < 3; k++) push_job(3 + k, acc);
        repeat (3) step();
        total++; if (start_log.size() != 3) begin bad++; $display("FAIL midrst_inflight got=%0d want=3", start_log.size()); end
        rst = 1'b0;
        #1;
        total++; if (bus.core_start !== '0 || bus.core_clear !== '0) begin bad++; $display("FAIL midrst_pulses got st=%b clr=%b want 0/0", bus.core_start, bus.core_clear); end
        total++; if (bus.cmp_valid !== 1'b0 || bus.cmp_id !== '0 || bus.cmp_core !== '0) begin bad++; $display("FAIL midrst_cmp got %b/%0d/%0d want 0/0/0", bus.cmp_valid, bus.cmp_id, bus.cmp_core); end
        total++; if (bus.job_ready !== 1'b1 || bus.idle !== 1'b1) begin bad++; $display("FAIL midrst_status got ready=%b idle=%b want 1/1", bus.job_ready, bus.idle); end
        @(posedge clk);
        #1 rst = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (bus.cmp_valid) saw = 1'b1;
        end
        total++; if (saw !== 1'b0 || bus.idle !== 1'b1) begin bad++; $display("FAIL midrst_after got cmp_seen=%b idle=%b want 0/1", saw, bus.idle); end
        done_r = '0; bus.core_done = '0;
    endtask

    task automatic test_random();
        int exp_q [$];
        int cj [NC][$];
        bit busy [NC];
        int clr_at [NC];
        int rr, next_id, n;
        do_reset();
        rand_dly = 1'b1;
        rr = 0; next_id = 0;
        for (int i = 0; i < NC; i++) begin busy[i] = 1'b0; clr_at[i] = -10; end
        for (int it = 0; it < 600; it++) begin
            bit en, v, acc;
            int expc;
            en = ($urandom_range(0, 9) < 8) || it >= 500;
            v  = ($urandom_range(0, 1) == 1) && it < 500;
            bus.sched_en  = en;
            bus.job_valid = v;
            bus.job_id    = IW'(next_id);
            total++; if (bus.job_ready !== (exp_q.size() < QD)) begin bad++; $display("FAIL rand_ready it=%0d got=%b want=%b", it, bus.job_ready, (exp_q.size() < QD)); end
            acc = v && bus.job_ready;
            expc = -1;
            if (en && exp_q.size() > 0) begin
                for (int j = 0; j < NC; j++) begin
                    int c;
                    c = (rr + j) % NC;
                    if (expc < 0 && !busy[c] && clr_at[c] <= cyc - 1) expc = c;
                end
            end
            if (expc >= 0) begin
                cj[expc].push_back(exp_q.pop_front());
                busy[expc] = 1'b1;
                rr = (expc + 1) % NC;
            end
            if (acc) begin exp_q.push_back(next_id); next_id = (next_id + 1) % 16; end
            step();
            total++; if (bus.core_start !== ((expc >= 0) ? NC'(1 << expc) : NC'(0))) begin bad++; $display("FAIL rand_start it=%0d got=%b want_core=%0d", it, bus.core_start, expc); end
            for (int c = 0; c < NC; c++) begin
                if (bus.core_clear[c]) begin busy[c] = 1'b0; clr_at[c] = cyc; end
            end
            if (bus.cmp_valid) begin
                int c;
                c = int'(bus.cmp_core);
                total++;
                if (cj[c].size() == 0) begin bad++; $display("FAIL rand_cmp_unexpected got core=%0d id=%0d want none", c, bus.cmp_id); end
                else begin
                    if (bus.cmp_id !== IW'(cj[c][0])) begin bad++; $display("FAIL rand_cmp_id got=%0d want=%0d core=%0d", bus.cmp_id, cj[c][0], c); end
                    void'(cj[c].pop_front());
                end
            end
        end
        n = 0;
        while (!bus.idle && n < 50) begin step(); n++; end
        n = exp_q.size();
        for (int c = 0; c < NC; c++) n += cj[c].size();
        total++; if (bus.idle !== 1'b1 || n != 0) begin bad++; $display("FAIL rand_drain got idle=%b outstanding=%0d want 1/0", bus.idle, n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_round_robin();
        test_collision();
        test_spurious();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
